// File: rtl/melody_sequencer.sv
// Alarm melody sequencer: plays a fixed note table as a piezo square wave with a fixed note and gap time.
// Optional build macro MELODY_LOOP_EN: the melody wraps back to note 0 instead of stopping.
module melody_sequencer #(
    parameter int NOTE_TICKS = 500000,
    parameter int GAP_TICKS  = 20000,
    parameter int NUM_NOTES  = 31
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       start,
    input  logic       stop,
    input  logic       mute,
    output logic       busy,
    output logic [4:0] note_idx,
    output logic       done,
    output logic       piezo
);

    localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int DW        = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;
    localparam logic [DW-1:0] NOTE_LAST = DW'(NOTE_TICKS - 1);
    localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_TICKS - 1);
    localparam logic [4:0]    LAST_NOTE = 5'(NUM_NOTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Half-period limit per note; the output toggles once the tone counter reaches it.
    function automatic logic [10:0] note_limit(input logic [4:0] idx);
        logic [10:0] lim;
        case (idx)
            5'd0:  lim = 11'd1516;
            5'd1:  lim = 11'd1701;
            5'd2:  lim = 11'd1910;
            5'd3:  lim = 11'd1701;
            5'd4:  lim = 11'd1516;
            5'd5:  lim = 11'd955;
            5'd6:  lim = 11'd955;
            5'd7:  lim = 11'd1135;
            5'd8:  lim = 11'd1275;
            5'd9:  lim = 11'd1516;
            5'd10: lim = 11'd1910;
            5'd11: lim = 11'd1701;
            5'd12: lim = 11'd1516;
            5'd13: lim = 11'd1275;
            5'd14: lim = 11'd1516;
            5'd15: lim = 11'd1701;
            5'd16: lim = 11'd1516;
            5'd17: lim = 11'd1701;
            5'd18: lim = 11'd1910;
            5'd19: lim = 11'd1701;
            5'd20: lim = 11'd1516;
            5'd21: lim = 11'd955;
            5'd22: lim = 11'd955;
            5'd23: lim = 11'd1135;
            5'd24: lim = 11'd1275;
            5'd25: lim = 11'd1135;
            5'd26: lim = 11'd1910;
            5'd27: lim = 11'd1701;
            5'd28: lim = 11'd1516;
            5'd29: lim = 11'd1701;
            5'd30: lim = 11'd1910;
            default: lim = 11'd0;
        endcase
        return lim;
    endfunction

    state_t        state_q, state_d;
    logic [4:0]    note_idx_q, note_idx_d;
    logic [10:0]   tone_cnt_q, tone_cnt_d;
    logic [DW-1:0] dur_cnt_q, dur_cnt_d;
    logic          tone_q, tone_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          piezo_q, piezo_d;
    logic          next_note_s;

    // Next-state, counter and output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        note_idx_d  = note_idx_q;
        tone_cnt_d  = tone_cnt_q;
        dur_cnt_d   = dur_cnt_q;
        tone_d      = tone_q;
        done_d      = 1'b0;
        next_note_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tone_d = 1'b0;
                if (start) begin
                    state_d    = ST_TONE;
                    note_idx_d = 5'd0;
                    tone_cnt_d = 11'd0;
                    dur_cnt_d  = {DW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TONE: begin
                if (tone_cnt_q == note_limit(note_idx_q)) begin
                    tone_d     = ~tone_q;
                    tone_cnt_d = 11'd0;
                end else begin
                    tone_cnt_d = tone_cnt_q + 11'd1;
                end
                // End of the tone phase always silences the output, gap or not.
                if (dur_cnt_q == NOTE_LAST) begin
                    tone_d     = 1'b0;
                    tone_cnt_d = 11'd0;
                    dur_cnt_d  = {DW{1'b0}};
                    if (GAP_TICKS == 0) begin
                        next_note_s = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    dur_cnt_d = dur_cnt_q + DW'(1);
                end
            end
            ST_GAP: begin
                tone_d = 1'b0;
                if (dur_cnt_q == GAP_LAST) begin
                    dur_cnt_d   = {DW{1'b0}};
                    next_note_s = 1'b1;
                end else begin
                    dur_cnt_d = dur_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                note_idx_d = 5'd0;
                tone_cnt_d = 11'd0;
                dur_cnt_d  = {DW{1'b0}};
                tone_d     = 1'b0;
            end
        endcase

        if (next_note_s) begin
            tone_cnt_d = 11'd0;
            dur_cnt_d  = {DW{1'b0}};
            tone_d     = 1'b0;
            if (note_idx_q < LAST_NOTE) begin
                note_idx_d = note_idx_q + 5'd1;
                state_d    = ST_TONE;
            end else begin
                note_idx_d = 5'd0;
                done_d     = 1'b1;
`ifdef MELODY_LOOP_EN
                state_d    = ST_TONE;
`else
                state_d    = ST_IDLE;
`endif
            end
        end else begin
            done_d = 1'b0;
        end

        // Abort has priority over everything, including a coincident start or wrap.
        if (stop) begin
            state_d    = ST_IDLE;
            note_idx_d = 5'd0;
            tone_cnt_d = 11'd0;
            dur_cnt_d  = {DW{1'b0}};
            tone_d     = 1'b0;
            done_d     = 1'b0;
        end else begin
            state_d = state_d;
        end

        busy_d  = (state_d != ST_IDLE);
        piezo_d = tone_d & ~mute;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            note_idx_q <= 5'd0;
            tone_cnt_q <= 11'd0;
            dur_cnt_q  <= {DW{1'b0}};
            tone_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            piezo_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_idx_q <= note_idx_d;
            tone_cnt_q <= tone_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_q     <= tone_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            piezo_q    <= piezo_d;
        end
    end

    assign busy     = busy_q;
    assign note_idx = note_idx_q;
    assign done     = done_q;
    assign piezo    = piezo_q;

endmodule
